// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA + decrypt stage: walks the encrypted ROM, XORs each byte with the
// keystream from S, writes plaintext out and aborts on a non-[a-z ] byte.
module prga_decrypt_fsm #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       key_bad,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_q,
    output logic [4:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_wren
);
    localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, RD_SI, WAIT_SI, CAP_SI, RD_SJ, WAIT_SJ, CAP_SJ, WR_SI,
        WR_SJ, RD_F, WAIT_F, CAP_F, CHECK, WR_OUT, DONE, BAD
    } state_t;

    state_t     state;
    logic [7:0] i, j, si, sj, f, m;
    logic [4:0] k;
    logic [7:0] d;
    logic       d_ok;

    assign d    = f ^ m;
    assign d_ok = ((d >= 8'h61) && (d <= 8'h7a)) || (d == 8'h20);

    // Every read holds its address for issue, WAIT and CAP, so q is sampled
    // two edges after the address appears whatever the memory latency (1 or 2).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            f     <= 8'd0;
            m     <= 8'd0;
            k     <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i     <= 8'd0;
                        j     <= 8'd0;
                        k     <= 5'd0;
                        state <= RD_SI;
                    end
                end
                RD_SI: begin
                    i     <= i + 8'd1;
                    state <= WAIT_SI;
                end
                WAIT_SI: state <= CAP_SI;
                CAP_SI: begin
                    si    <= s_q;
                    j     <= j + s_q;
                    state <= RD_SJ;
                end
                RD_SJ:   state <= WAIT_SJ;
                WAIT_SJ: state <= CAP_SJ;
                CAP_SJ: begin
                    sj    <= s_q;
                    state <= WR_SI;
                end
                WR_SI:  state <= WR_SJ;
                WR_SJ:  state <= RD_F;
                RD_F:   state <= WAIT_F;
                WAIT_F: state <= CAP_F;
                CAP_F: begin
                    f     <= s_q;
                    m     <= rom_q;
                    state <= CHECK;
                end
                CHECK:  state <= d_ok ? WR_OUT : BAD;
                WR_OUT: begin
                    if (k == K_LAST) begin
                        state <= DONE;
                    end else begin
                        k     <= k + 5'd1;
                        state <= RD_SI;
                    end
                end
                DONE:    state <= IDLE;
                BAD:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode of the state register: strobes drop the instant reset
    // forces IDLE, and address/data are valid in the strobe's own cycle.
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        key_bad  = (state == BAD);
        s_addr   = 8'd0;
        s_wdata  = 8'd0;
        s_wren   = 1'b0;
        rom_addr = 5'd0;
        out_addr = 5'd0;
        out_data = 8'd0;
        out_wren = 1'b0;
        case (state)
            RD_SI:                  s_addr = i + 8'd1;
            WAIT_SI, CAP_SI:        s_addr = i;
            RD_SJ, WAIT_SJ, CAP_SJ: s_addr = j;
            // S[i] first then S[j]: when i == j the second write restores si.
            WR_SI: begin
                s_addr  = i;
                s_wdata = sj;
                s_wren  = 1'b1;
            end
            WR_SJ: begin
                s_addr  = j;
                s_wdata = si;
                s_wren  = 1'b1;
            end
            RD_F, WAIT_F, CAP_F: begin
                s_addr   = si + sj;
                rom_addr = k;
            end
            WR_OUT: begin
                out_addr = k;
                out_data = d;
                out_wren = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Self-checking bench for prga_decrypt_fsm: single-byte vector table, full RC4
// passes from a software keystream model, restart/abort/reset corner cases.
module tb_prga_decrypt_fsm;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, key_bad, s_wren, out_wren;
    logic [7:0] s_addr, s_wdata, s_q, rom_q, out_data;
    logic [4:0] rom_addr, out_addr;

    prga_decrypt_fsm #(.MSG_LEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .key_bad(key_bad), .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren),
        .s_q(s_q), .rom_addr(rom_addr), .rom_q(rom_q), .out_addr(out_addr),
        .out_data(out_data), .out_wren(out_wren)
    );

    always #5 clk = ~clk;

    // Memories: synchronous read, one edge of latency.
    logic [7:0] smem [256];
    logic [7:0] sinit[256];
    logic [7:0] rom  [32];
    logic       load_s = 1'b0;

    always @(posedge clk) begin
        if (load_s) begin
            for (int a = 0; a < 256; a++) smem[a] <= sinit[a];
        end else if (s_wren) begin
            smem[s_addr] <= s_wdata;
        end
        s_q   <= smem[s_addr];
        rom_q <= rom[rom_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ks[32], sfin[256], plain[32], exp_d[32];
    int nexp, exp_cyc;
    bit exp_bad;

    function automatic bit is_valid(input logic [7:0] x);
        return ((x >= 8'h61) && (x <= 8'h7a)) || (x == 8'h20);
    endfunction

    function automatic void prga_ks();
        int ii = 0, jj = 0;
        logic [7:0] t;
        for (int a = 0; a < 256; a++) sfin[a] = sinit[a];
        for (int n = 0; n < 32; n++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(sfin[ii])) % 256;
            t = sfin[ii]; sfin[ii] = sfin[jj]; sfin[jj] = t;
            ks[n] = sfin[(int'(sfin[ii]) + int'(sfin[jj])) % 256];
        end
    endfunction

    function automatic void model();
        logic [7:0] dd;
        prga_ks();
        nexp = 0;
        exp_bad = 1'b0;
        for (int n = 0; n < 32; n++) begin
            dd = ks[n] ^ rom[n];
            if (!is_valid(dd)) begin
                exp_bad = 1'b1;
                break;
            end
            exp_d[nexp] = dd;
            nexp++;
        end
        exp_cyc = exp_bad ? 13 * nexp + 13 : 13 * 32 + 1;
    endfunction

    function automatic void build_rom();
        prga_ks();
        for (int n = 0; n < 32; n++) rom[n] = ks[n] ^ plain[n];
    endfunction

    function automatic void set_identity();
        for (int a = 0; a < 256; a++) sinit[a] = 8'(a);
    endfunction

    function automatic void set_ksa(input logic [23:0] key);
        logic [7:0] kb[3];
        logic [7:0] t;
        int jj = 0;
        kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
        set_identity();
        for (int a = 0; a < 256; a++) begin
            jj = (jj + int'(sinit[a]) + int'(kb[a % 3])) % 256;
            t = sinit[a]; sinit[a] = sinit[jj]; sinit[jj] = t;
        end
    endfunction

    function automatic void rand_plain();
        int r;
        for (int n = 0; n < 32; n++) begin
            r = $urandom_range(26, 0);
            plain[n] = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic load_mem();
        @(negedge clk); load_s = 1'b1;
        @(negedge clk); load_s = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic start_pass();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_pass(input string nm, input int restart_cyc);
        int  cyc = 0, nwr = 0, ev_cyc = -1, mism = 0;
        bit  ended = 1'b0, saw_bad = 1'b0, both = 1'b0;
        model();
        start_pass();
        while (!ended && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_cyc);
            if (out_wren) begin
                if (nwr < nexp) begin
                    chk($sformatf("%s wr%0d addr", nm, nwr), int'(out_addr), nwr);
                    chk($sformatf("%s wr%0d data", nm, nwr), int'(out_data), int'(exp_d[nwr]));
                end
                nwr++;
            end
            if (done && key_bad) both = 1'b1;
            if ((done || key_bad) && ev_cyc < 0) begin
                ev_cyc  = cyc;
                saw_bad = key_bad;
            end
            if (ev_cyc > 0 && cyc == ev_cyc + 1) begin
                chk($sformatf("%s busy after end", nm), int'(busy), 0);
                ended = 1'b1;
            end
        end
        start = 1'b0;
        chk($sformatf("%s finished in budget", nm), int'(ended), 1);
        chk($sformatf("%s done&key_bad overlap", nm), int'(both), 0);
        chk($sformatf("%s write count", nm), nwr, nexp);
        chk($sformatf("%s end cycle", nm), ev_cyc, exp_cyc);
        chk($sformatf("%s key_bad outcome", nm), int'(saw_bad), int'(exp_bad));
        if (!exp_bad) begin
            for (int a = 0; a < 256; a++) if (smem[a] !== sfin[a]) mism++;
            chk($sformatf("%s final S mismatches", nm), mism, 0);
        end
    endtask

    // ---------------- single-byte vector table (identity S: d = rom0 ^ 2) ----
    typedef struct {
        logic [7:0] rom0;
        bit         bad;
        logic [7:0] d;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h63, 1'b0, 8'h61};
        vecs[1] = '{8'h00, 1'b1, 8'h02};
        vecs[2] = '{8'h22, 1'b0, 8'h20};
        vecs[3] = '{8'h78, 1'b0, 8'h7a};
        vecs[4] = '{8'h79, 1'b1, 8'h7b};
        vecs[5] = '{8'h62, 1'b1, 8'h60};
        vecs[6] = '{8'h23, 1'b1, 8'h21};
        vecs[7] = '{8'h1d, 1'b1, 8'h1f};

        for (int n = 0; n < 32; n++) rom[n] = 8'h00;
        #12;
        chk("reset strobes", int'({busy, done, key_bad, s_wren, out_wren}), 0);
        chk("reset s_addr/s_wdata", int'({s_addr, s_wdata}), 0);
        chk("reset rom/out bus", int'({rom_addr, out_addr, out_data}), 0);
        @(negedge clk); reset_n = 1'b1;

        for (int t = 0; t < 8; t++) begin
            bit stray = 1'b0;
            set_identity();
            load_mem();
            rom[0] = vecs[t].rom0;
            start_pass();
            for (int c = 1; c <= 14; c++) begin
                @(negedge clk);
                if (c == 7 || c == 8) begin
                    chk($sformatf("v%0d c%0d s write", t, c),
                        int'({s_wren, s_addr, s_wdata}), int'({1'b1, 8'h01, 8'h01}));
                end
                if (c == 13) begin
                    chk($sformatf("v%0d key_bad", t), int'(key_bad), int'(vecs[t].bad));
                    chk($sformatf("v%0d out_wren", t), int'(out_wren), int'(!vecs[t].bad));
                    if (!vecs[t].bad)
                        chk($sformatf("v%0d out addr/data", t),
                            int'({out_addr, out_data}), int'({5'd0, vecs[t].d}));
                end else if (key_bad || out_wren || done) begin
                    stray = 1'b1;
                end
                if (c == 14) begin
                    chk($sformatf("v%0d busy c14", t), int'(busy), int'(!vecs[t].bad));
                    if (!vecs[t].bad)
                        chk($sformatf("v%0d next RD_SI addr", t), int'({s_wren, s_addr}), 2);
                end
            end
            chk($sformatf("v%0d stray strobes", t), int'(stray), 0);
            do_reset();
        end

        // Full pass: KSA key 0x000249, plaintext "abc...z" + "abcdef".
        set_ksa(24'h000249);
        for (int n = 0; n < 32; n++) plain[n] = 8'h61 + 8'(n % 26);
        build_rom();
        load_mem();
        run_pass("full", 0);

        // Same pass with a start pulse in cycle 50: must be ignored.
        load_mem();
        run_pass("restart50", 50);

        // Last byte corrupted to give 'A'.
        plain[31] = 8'h41;
        build_rom();
        load_mem();
        run_pass("lastbad", 0);

        // Randomized S permutations and messages, some with a bad byte.
        for (int r = 0; r < 5; r++) begin
            logic [7:0] t8;
            int         b;
            set_identity();
            for (int a = 255; a > 0; a--) begin
                b = $urandom_range(a, 0);
                t8 = sinit[a]; sinit[a] = sinit[b]; sinit[b] = t8;
            end
            rand_plain();
            if (r % 2 == 1) begin
                b = $urandom_range(31, 0);
                do t8 = 8'($urandom_range(255, 0)); while (is_valid(t8));
                plain[b] = t8;
            end
            build_rom();
            load_mem();
            run_pass($sformatf("rand%0d", r), 0);
        end

        // Reset dropped during WR_SI of the first byte.
        set_identity();
        rand_plain();
        build_rom();
        load_mem();
        start_pass();
        repeat (7) @(negedge clk);
        chk("midreset WR_SI active", int'(s_wren), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset strobes", int'({busy, done, key_bad, s_wren, out_wren}), 0);
        chk("midreset buses", int'({s_addr, s_wdata, rom_addr, out_addr}), 0);
        @(negedge clk); reset_n = 1'b1;
        load_mem();
        run_pass("after_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
